// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for an RV32 core with a shared memory port.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues the datapath
// enables for that step. It also runs the mem_ready wait handshake, including a
// timeout on a wait that lasts too long.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        sub_en,
  output logic        illegal,
  output logic        bus_err,
  output logic        instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
    CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_ILLEGAL
  } iclass_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          iclass;
  logic             timeout;

  // Instruction bits this controller does not look at.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify the opcode held in the IR.
  always_comb begin
    unique case (instr[6:0])
      7'b0110111: iclass = CL_LUI;
      7'b0010111: iclass = CL_AUIPC;
      7'b1101111: iclass = CL_JAL;
      7'b1100111: iclass = CL_JALR;
      7'b1100011: iclass = CL_BRANCH;
      7'b0000011: iclass = CL_LOAD;
      7'b0100011: iclass = CL_STORE;
      7'b0010011: iclass = CL_OPIMM;
      7'b0110011: iclass = CL_OP;
      default:    iclass = CL_ILLEGAL;
    endcase
  end

  // A wait on the memory port expires when the counter has reached WAIT_MAX and the port is still not ready.
  assign timeout = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready &&
                   (cnt_q == CNT_W'(WAIT_MAX));

  // Next state and all datapath controls, decoded from the current state and the inputs.
  always_comb begin
    // NOTE: every output gets a default before the case, so a path that does not
    // assign it cannot infer a latch.
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    reg_we   = 1'b0;
    wb_sel   = 2'd0;
    sub_en   = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    instret  = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;  // re-issue the fetch; PC holds
        end
      end
      DECODE: begin
        if (iclass == CL_ILLEGAL) begin
          pc_we   = 1'b1;
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (iclass)
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? 2'd1 : 2'd0;
            instret = 1'b1;
            state_d = FETCH;
          end
          CL_JAL, CL_JALR: begin
            reg_we  = 1'b1;
            wb_sel  = 2'd2;
            pc_we   = 1'b1;
            pc_sel  = (iclass == CL_JAL) ? 2'd1 : 2'd2;
            instret = 1'b1;
            state_d = FETCH;
          end
          CL_LOAD, CL_STORE: state_d = MEM;
          CL_LUI, CL_AUIPC, CL_OP, CL_OPIMM: state_d = WB;
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (iclass == CL_STORE);
        if (mem_ready) begin
          if (iclass == CL_STORE) begin
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout) begin
          bus_err = 1'b1;  // abort: skip the instruction without retiring it
          pc_we   = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        reg_we  = 1'b1;
        wb_sel  = (iclass == CL_LOAD) ? 2'd1 : 2'd0;
        pc_we   = 1'b1;
        instret = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (((state_q == EXEC) || (state_q == WB)) && (iclass == CL_OP) &&
        (instr[14:12] == 3'b000) && instr[30])
      sub_en = 1'b1;

    // Reset silences every enable in the same cycle it is raised.
    if (rst) begin
      state_d  = FETCH;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
      reg_we   = 1'b0;
      wb_sel   = 2'd0;
      sub_en   = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      instret  = 1'b0;
    end
  end

  // The wait counter restarts on any state change or timeout and counts cycles not yet ready in FETCH/MEM.
  always_comb begin
    cnt_d = cnt_q;
    if (rst || (state_d != state_q) || timeout)
      cnt_d = '0;
    else if (((state_q == FETCH) || (state_q == MEM)) && !mem_ready)
      cnt_d = cnt_q + 1'b1;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its value from before the clock edge.
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of per-cycle vectors, then
// hand-built sequences for the wait, timeout and reset corners. Each cycle pushes
// its expected outputs to a scoreboard queue. The entry is popped and compared at
// the falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       sub_en;
    logic       illegal;
    logic       bus_err;
    logic       instret;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic        br;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_LUI  = 32'h000010B7;
  localparam logic [31:0] I_ILL  = 32'h0000000B;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic [2:0]  state;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]  pc_sel, wb_sel;
  logic        sub_en, illegal, bus_err, instret;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  outs_t exp_q[$];
  vec_t  vecs[$];

  multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .sub_en(sub_en), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  // Build an expected-output record.
  function automatic outs_t mk(input int st, input bit req, input bit we, input bit asel,
                               input bit irwe, input bit pcwe, input int pcsel,
                               input bit regwe, input int wbsel, input bit sub,
                               input bit ill, input bit berr, input bit iret);
    outs_t o;
    o.state    = 3'(st);
    o.mem_req  = req;
    o.mem_we   = we;
    o.addr_sel = asel;
    o.ir_we    = irwe;
    o.pc_we    = pcwe;
    o.pc_sel   = 2'(pcsel);
    o.reg_we   = regwe;
    o.wb_sel   = 2'(wbsel);
    o.sub_en   = sub;
    o.illegal  = ill;
    o.bus_err  = berr;
    o.instret  = iret;
    return o;
  endfunction

  function automatic vec_t v(input logic r, input logic [31:0] i, input logic rdy,
                             input logic br, input outs_t e);
    vec_t x;
    x.rst = r; x.instr = i; x.rdy = rdy; x.br = br; x.exp = e;
    return x;
  endfunction

  // Common expected patterns.
  function automatic outs_t o_zero(input int st);
    return mk(st, 0,0,0,0,0,0,0,0,0,0,0,0);
  endfunction
  function automatic outs_t o_fetch_wait();
    return mk(0, 1,0,0,0,0,0,0,0,0,0,0,0);
  endfunction
  function automatic outs_t o_fetch_done();
    return mk(0, 1,0,0,1,0,0,0,0,0,0,0,0);
  endfunction
  function automatic outs_t o_mem(input bit we);
    return mk(3, 1,we,1,0,0,0,0,0,0,0,0,0);
  endfunction

  task automatic compare();
    outs_t e, got;
    e   = exp_q.pop_front();
    got = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel,
           sub_en, illegal, bus_err, instret};
    n_checks++;
    if (got === e) n_pass++;
    else $display("FAIL cycle%0d outputs: got state=%0d req=%b we=%b asel=%b irwe=%b pcwe=%b pcsel=%0d regwe=%b wbsel=%0d sub=%b ill=%b berr=%b iret=%b, expected state=%0d req=%b we=%b asel=%b irwe=%b pcwe=%b pcsel=%0d regwe=%b wbsel=%0d sub=%b ill=%b berr=%b iret=%b",
                  cyc, got.state, got.mem_req, got.mem_we, got.addr_sel, got.ir_we, got.pc_we,
                  got.pc_sel, got.reg_we, got.wb_sel, got.sub_en, got.illegal, got.bus_err, got.instret,
                  e.state, e.mem_req, e.mem_we, e.addr_sel, e.ir_we, e.pc_we,
                  e.pc_sel, e.reg_we, e.wb_sel, e.sub_en, e.illegal, e.bus_err, e.instret);
  endtask

  // Drive one cycle of inputs, queue its expectation, check at the falling edge.
  task automatic step(input logic r, input logic [31:0] i, input logic rdy, input logic br,
                      input outs_t e);
    rst = r; instr = i; mem_ready = rdy; br_taken = br;
    exp_q.push_back(e);
    @(negedge clk);
    compare();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Fetch (ready at once) followed by the DECODE and EXEC cycles for a non-jump, non-branch instruction.
  task automatic front(input logic [31:0] i);
    step(0, i, 1, 0, o_fetch_done());
    step(0, i, 0, 0, o_zero(1));
    step(0, i, 0, 0, o_zero(2));
  endtask

  initial begin
    rst = 1'b1; instr = I_ADD; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk);
    #1;

    // ---- table-driven vectors ----
    // reset
    vecs.push_back(v(1, I_ADD, 1, 0, o_zero(0)));
    vecs.push_back(v(1, I_ADD, 0, 0, o_zero(0)));
    // ADD: 0,1,2,4
    vecs.push_back(v(0, I_ADD, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_ADD, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_ADD, 0, 0, o_zero(2)));
    vecs.push_back(v(0, I_ADD, 0, 0, mk(4, 0,0,0,0,1,0,1,0,0,0,0,1)));
    // SUB: sub_en only in EXEC and WB
    vecs.push_back(v(0, I_SUB, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_SUB, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_SUB, 0, 0, mk(2, 0,0,0,0,0,0,0,0,1,0,0,0)));
    vecs.push_back(v(0, I_SUB, 0, 0, mk(4, 0,0,0,0,1,0,1,0,1,0,0,1)));
    // SW, ready at once in MEM
    vecs.push_back(v(0, I_SW, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_SW, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_SW, 0, 0, o_zero(2)));
    vecs.push_back(v(0, I_SW, 1, 0, mk(3, 1,1,1,0,1,0,0,0,0,0,0,1)));
    // BEQ taken (mem_ready in DECODE ignored)
    vecs.push_back(v(0, I_BEQ, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_BEQ, 1, 1, o_zero(1)));
    vecs.push_back(v(0, I_BEQ, 0, 1, mk(2, 0,0,0,0,1,1,0,0,0,0,0,1)));
    // BEQ not taken
    vecs.push_back(v(0, I_BEQ, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_BEQ, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_BEQ, 1, 0, mk(2, 0,0,0,0,1,0,0,0,0,0,0,1)));
    // JAL
    vecs.push_back(v(0, I_JAL, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_JAL, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_JAL, 0, 0, mk(2, 0,0,0,0,1,1,1,2,0,0,0,1)));
    // JALR
    vecs.push_back(v(0, I_JALR, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_JALR, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_JALR, 0, 0, mk(2, 0,0,0,0,1,2,1,2,0,0,0,1)));
    // illegal opcode
    vecs.push_back(v(0, I_ILL, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_ILL, 1, 0, mk(1, 0,0,0,0,1,0,0,0,0,1,0,0)));
    // LUI with one fetch wait cycle
    vecs.push_back(v(0, I_LUI, 0, 0, o_fetch_wait()));
    vecs.push_back(v(0, I_LUI, 1, 0, o_fetch_done()));
    vecs.push_back(v(0, I_LUI, 0, 0, o_zero(1)));
    vecs.push_back(v(0, I_LUI, 0, 0, o_zero(2)));
    vecs.push_back(v(0, I_LUI, 1, 0, mk(4, 0,0,0,0,1,0,1,0,0,0,0,1)));

    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k].rst, vecs[k].instr, vecs[k].rdy, vecs[k].br, vecs[k].exp);

    // ---- LW: three wait cycles in MEM, then WB from memory ----
    front(I_LW);
    for (int k = 0; k < 3; k++) step(0, I_LW, 0, 0, o_mem(0));
    step(0, I_LW, 1, 0, o_mem(0));
    step(0, I_LW, 0, 0, mk(4, 0,0,0,0,1,0,1,1,0,0,0,1));

    // ---- LW timeout: 16th waiting MEM cycle aborts ----
    front(I_LW);
    for (int k = 0; k < 15; k++) step(0, I_LW, 0, 0, o_mem(0));
    step(0, I_LW, 0, 0, mk(3, 1,0,1,0,1,0,0,0,0,0,1,0));
    step(0, I_ADD, 1, 0, o_fetch_done());
    step(0, I_ADD, 0, 0, o_zero(1));
    step(0, I_ADD, 0, 0, o_zero(2));
    step(0, I_ADD, 0, 0, mk(4, 0,0,0,0,1,0,1,0,0,0,0,1));

    // ---- ready on the would-be timeout cycle counts as completion ----
    front(I_LW);
    for (int k = 0; k < 15; k++) step(0, I_LW, 0, 0, o_mem(0));
    step(0, I_LW, 1, 0, o_mem(0));
    step(0, I_LW, 0, 0, mk(4, 0,0,0,0,1,0,1,1,0,0,0,1));

    // ---- FETCH timeout: re-issue, counter restarts ----
    for (int k = 0; k < 15; k++) step(0, I_ADD, 0, 0, o_fetch_wait());
    step(0, I_ADD, 0, 0, mk(0, 1,0,0,0,0,0,0,0,0,0,1,0));
    for (int k = 0; k < 15; k++) step(0, I_ADD, 0, 0, o_fetch_wait());
    step(0, I_ADD, 1, 0, o_fetch_done());
    step(0, I_ADD, 0, 0, o_zero(1));
    step(0, I_ADD, 0, 0, o_zero(2));
    step(0, I_ADD, 0, 0, mk(4, 0,0,0,0,1,0,1,0,0,0,0,1));

    // ---- reset on the 2nd MEM cycle of a store ----
    front(I_SW);
    step(0, I_SW, 0, 0, o_mem(1));
    step(1, I_SW, 0, 0, o_zero(3));
    step(1, I_SW, 1, 0, o_zero(0));
    step(0, I_ADD, 0, 0, o_fetch_wait());
    step(0, I_ADD, 1, 0, o_fetch_done());
    step(0, I_ADD, 0, 0, o_zero(1));

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
